// File: rtl/temporizador_descendente.sv
// Loadable down-counting timer: counts load_val prescaled ticks, then emits a
// one-cycle done pulse. Supports pause, abort and retrigger.
module temporizador_descendente #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             pause,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] remaining
);

  localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSED,
    ST_DONE
  } state_t;

  state_t          state_q,     state_d;
  logic [WIDTH-1:0] remaining_q, remaining_d;
  logic [PS_W-1:0]  prescaler_q, prescaler_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;
  logic             tick;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    prescaler_d = prescaler_q;
    tick        = (prescaler_q == PS_LAST);

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          prescaler_d = '0;
          if (load_val == '0) begin
            state_d     = ST_DONE;
            remaining_d = '0;
          end else begin
            state_d     = ST_RUN;
            remaining_d = load_val;
          end
        end
      end

      ST_RUN, ST_PAUSED: begin
        if (abort) begin
          state_d     = ST_IDLE;
          remaining_d = '0;
          prescaler_d = '0;
        end else if (start) begin
          prescaler_d = '0;
          if (load_val == '0) begin
            state_d     = ST_DONE;
            remaining_d = '0;
          end else begin
            state_d     = ST_RUN;
            remaining_d = load_val;
          end
        end else if (pause) begin
          state_d = ST_PAUSED;
        end else begin
          // The cycle that leaves PAUSED counts like a RUN cycle, so each
          // paused cycle costs exactly one cycle of latency.
          state_d = ST_RUN;
          if (tick) begin
            prescaler_d = '0;
            if (remaining_q <= WIDTH'(1)) begin
              state_d     = ST_DONE;
              remaining_d = '0;
            end else begin
              remaining_d = remaining_q - WIDTH'(1);
            end
          end else begin
            prescaler_d = prescaler_q + PS_W'(1);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSED);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      prescaler_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      prescaler_q <= prescaler_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign remaining = remaining_q;

endmodule

// File: tb/tb_temporizador_descendente.sv
// Scoreboard bench for temporizador_descendente: PRESCALE=4 instance (a) and
// PRESCALE=1 instance (b); expected per-cycle outputs and done cycles are queued.
module tb_temporizador_descendente;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_a, pause_a, abort_a, busy_a, done_a;
  logic [7:0] load_a, rem_a;
  logic       start_b, pause_b, abort_b, busy_b, done_b;
  logic [7:0] load_b, rem_b;

  temporizador_descendente #(.WIDTH(8), .PRESCALE(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .load_val(load_a), .pause(pause_a),
    .abort(abort_a), .busy(busy_a), .done(done_a), .remaining(rem_a)
  );

  temporizador_descendente #(.WIDTH(8), .PRESCALE(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .load_val(load_b), .pause(pause_b),
    .abort(abort_b), .busy(busy_b), .done(done_b), .remaining(rem_b)
  );

  typedef struct {
    int         cyc;
    logic       busy;
    logic       done;
    logic [7:0] rem;
  } chk_t;

  chk_t qa[$], qb[$];
  int   da[$], db[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic push_chk(input bit sel, input int c, input logic b, input logic d, input int r);
    chk_t e;
    e.cyc  = c;
    e.busy = b;
    e.done = d;
    e.rem  = 8'(r);
    if (sel) qb.push_back(e);
    else     qa.push_back(e);
  endtask

  // Clean run of n ticks reloaded in cycle s: busy s+1..s+n*p, done at s+n*p+1.
  task automatic exp_run(input bit sel, input int s, input int n, input int p);
    for (int c = s + 1; c <= s + n * p; c++) push_chk(sel, c, 1'b1, 1'b0, n - (c - s - 1) / p);
    push_chk(sel, s + n * p + 1, 1'b0, 1'b1, 0);
    if (sel) db.push_back(s + n * p + 1);
    else     da.push_back(s + n * p + 1);
  endtask

  always @(negedge clk) begin : mon_a
    chk_t e;
    while (qa.size() > 0 && qa[0].cyc <= cyc) begin
      e = qa.pop_front();
      cmp("a_check_cycle", cyc, e.cyc);
      cmp("a_busy", busy_a, e.busy);
      cmp("a_done", done_a, e.done);
      cmp("a_remaining", rem_a, e.rem);
    end
    if (done_a === 1'b1) begin
      if (da.size() == 0) cmp("a_unexpected_done", done_a, 0);
      else                cmp("a_done_cycle", cyc, da.pop_front());
    end
  end

  always @(negedge clk) begin : mon_b
    chk_t e;
    while (qb.size() > 0 && qb[0].cyc <= cyc) begin
      e = qb.pop_front();
      cmp("b_check_cycle", cyc, e.cyc);
      cmp("b_busy", busy_b, e.busy);
      cmp("b_done", done_b, e.done);
      cmp("b_remaining", rem_b, e.rem);
    end
    if (done_b === 1'b1) begin
      if (db.size() == 0) cmp("b_unexpected_done", done_b, 0);
      else                cmp("b_done_cycle", cyc, db.pop_front());
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) sync();
  endtask

  int b;

  initial begin
    rst = 1'b0;
    start_a = 1'b1; load_a = 8'd5; pause_a = 1'b0; abort_a = 1'b0;
    start_b = 1'b1; load_b = 8'd5; pause_b = 1'b0; abort_b = 1'b0;

    // Reset held two cycles with start asserted, then first cycle after release
    sync();
    b = cyc;
    for (int c = 0; c <= 2; c++) push_chk(0, b + c, 1'b0, 1'b0, 0);
    sync();
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;

    // Basic countdown of 3 ticks
    sync();
    b = cyc;
    start_a = 1'b1; load_a = 8'd3;
    exp_run(0, b, 3, 4);
    push_chk(0, b + 14, 1'b0, 1'b0, 0);
    sync();
    start_a = 1'b0;
    wait_until(b + 16);

    // Zero-length timer
    b = cyc;
    start_a = 1'b1; load_a = 8'd0;
    exp_run(0, b, 0, 4);
    push_chk(0, b + 2, 1'b0, 1'b0, 0);
    sync();
    start_a = 1'b0;
    wait_until(b + 4);

    // Pause during cycles 3..7 of a 2-tick run
    b = cyc;
    start_a = 1'b1; load_a = 8'd2;
    for (int c = 1; c <= 13; c++) push_chk(0, b + c, 1'b1, 1'b0, (c <= 9) ? 2 : 1);
    push_chk(0, b + 14, 1'b0, 1'b1, 0);
    push_chk(0, b + 15, 1'b0, 1'b0, 0);
    da.push_back(b + 14);
    sync();
    start_a = 1'b0;
    wait_until(b + 3);
    pause_a = 1'b1;
    wait_until(b + 8);
    pause_a = 1'b0;
    wait_until(b + 17);

    // Abort in cycle 4 of a 2-tick run
    b = cyc;
    start_a = 1'b1; load_a = 8'd2;
    for (int c = 1; c <= 4; c++) push_chk(0, b + c, 1'b1, 1'b0, 2);
    for (int c = 5; c <= 10; c++) push_chk(0, b + c, 1'b0, 1'b0, 0);
    sync();
    start_a = 1'b0;
    wait_until(b + 4);
    abort_a = 1'b1;
    sync();
    abort_a = 1'b0;
    wait_until(b + 12);

    // Retrigger with load 5 at cycle 6
    b = cyc;
    start_a = 1'b1; load_a = 8'd2;
    for (int c = 1; c <= 6; c++) push_chk(0, b + c, 1'b1, 1'b0, (c <= 4) ? 2 : 1);
    exp_run(0, b + 6, 5, 4);
    push_chk(0, b + 28, 1'b0, 1'b0, 0);
    sync();
    start_a = 1'b0;
    wait_until(b + 6);
    start_a = 1'b1; load_a = 8'd5;
    sync();
    start_a = 1'b0;
    wait_until(b + 30);

    // Abort and start in the same RUN cycle: abort wins
    b = cyc;
    start_a = 1'b1; load_a = 8'd3;
    for (int c = 1; c <= 2; c++) push_chk(0, b + c, 1'b1, 1'b0, 3);
    for (int c = 3; c <= 16; c++) push_chk(0, b + c, 1'b0, 1'b0, 0);
    sync();
    start_a = 1'b0;
    wait_until(b + 2);
    abort_a = 1'b1; start_a = 1'b1; load_a = 8'd7;
    sync();
    abort_a = 1'b0; start_a = 1'b0;
    wait_until(b + 18);

    // Start accepted in the DONE cycle: back-to-back runs
    b = cyc;
    start_a = 1'b1; load_a = 8'd1;
    exp_run(0, b, 1, 4);
    exp_run(0, b + 5, 2, 4);
    push_chk(0, b + 15, 1'b0, 1'b0, 0);
    sync();
    start_a = 1'b0;
    wait_until(b + 5);
    start_a = 1'b1; load_a = 8'd2;
    sync();
    start_a = 1'b0;
    wait_until(b + 17);

    // Reset mid-run: no done pulse afterwards
    b = cyc;
    start_a = 1'b1; load_a = 8'd4;
    for (int c = 1; c <= 5; c++) push_chk(0, b + c, 1'b1, 1'b0, (c <= 4) ? 4 : 3);
    for (int c = 6; c <= 24; c++) push_chk(0, b + c, 1'b0, 1'b0, 0);
    sync();
    start_a = 1'b0;
    wait_until(b + 5);
    rst = 1'b0;
    sync();
    rst = 1'b1;
    wait_until(b + 26);

    // PRESCALE=1, maximum load
    b = cyc;
    start_b = 1'b1; load_b = 8'd255;
    exp_run(1, b, 255, 1);
    push_chk(1, b + 257, 1'b0, 1'b0, 0);
    sync();
    start_b = 1'b0;
    wait_until(b + 260);

    wait_until(cyc + 3);
    while (da.size() > 0) cmp("a_missing_done", -1, da.pop_front());
    while (db.size() > 0) cmp("b_missing_done", -1, db.pop_front());
    cmp("a_pending_checks", qa.size(), 0);
    cmp("b_pending_checks", qb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
